// File: rtl/kulisch_to_fp16.sv
// Three-stage normalizer: signed Kulisch accumulator word -> IEEE binary16 (RNE),
// with valid/ready flow control, saturation to +/-Inf and an inexact flag.
module kulisch_to_fp16 #(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned EWIDTH = 5,
  parameter int unsigned MWIDTH = 10,
  parameter int unsigned BIAS   = 15,
  parameter int unsigned WWIDTH = 79,
  parameter int unsigned FBITS  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [WWIDTH-1:0] i_kulisch_acc,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DWIDTH-1:0] o_fp_data,
  output logic              o_overflow,
  output logic              o_inexact
);

  localparam int unsigned PW     = $clog2(WWIDTH);
  localparam int unsigned XW     = PW + 1;
  localparam int unsigned MW1    = MWIDTH + 1;
  localparam int unsigned EMAX_I = (1 << EWIDTH) - 1;

  logic r1, r2, r3;

  logic              v1_q, v1_d, sign1_q, sign1_d, zero1_q, zero1_d;
  logic [WWIDTH-1:0] mag1_q, mag1_d;

  logic              v2_q, v2_d, sign2_q, sign2_d, zero2_q, zero2_d;
  logic [PW-1:0]     p2_q, p2_d;
  logic [WWIDTH-1:0] norm2_q, norm2_d;

  logic              v3_q, v3_d, ovf3_q, ovf3_d, inx3_q, inx3_d;
  logic [DWIDTH-1:0] data3_q, data3_d;

  logic [PW-1:0]     lead_p;
  logic [WWIDTH-1:0] abs_word;
  logic [MWIDTH-1:0] mant_hi, sub_mant;
  logic              guard, sticky, round_up;
  logic [MW1-1:0]    mant_r;
  logic [XW-1:0]     exp_pre, exp_r;

  // Ready ripples back from the consumer so bubbles anywhere in the pipe collapse.
  assign r3      = !v3_q || i_ready;
  assign r2      = !v2_q || r3;
  assign r1      = !v1_q || r2;
  assign o_ready = r1;

  assign o_valid    = v3_q;
  assign o_fp_data  = data3_q;
  assign o_overflow = ovf3_q;
  assign o_inexact  = inx3_q;

  // Most negative word negates to itself, which reads correctly as unsigned 2^(W-1).
  assign abs_word = i_kulisch_acc[WWIDTH-1] ? (~i_kulisch_acc + WWIDTH'(1)) : i_kulisch_acc;

  always_comb begin
    lead_p = '0;
    for (int unsigned i = 0; i < WWIDTH; i++) begin
      if (mag1_q[i]) lead_p = PW'(i);
    end
  end

  assign mant_hi  = norm2_q[WWIDTH-2 -: MWIDTH];
  assign guard    = norm2_q[WWIDTH-2-MWIDTH];
  assign sticky   = |norm2_q[WWIDTH-3-MWIDTH:0];
  assign sub_mant = norm2_q[WWIDTH-1 -: MWIDTH] >> (PW'(MWIDTH - 1) - p2_q);
  assign round_up = guard && (sticky || mant_hi[0]);
  assign mant_r   = {1'b0, mant_hi} + MW1'(round_up);
  assign exp_pre  = {1'b0, p2_q} + XW'(BIAS) - XW'(FBITS);
  assign exp_r    = exp_pre + XW'(mant_r[MWIDTH]);

  always_comb begin
    v1_d    = v1_q;
    sign1_d = sign1_q;
    zero1_d = zero1_q;
    mag1_d  = mag1_q;
    if (r1) begin
      v1_d = i_valid;
      if (i_valid) begin
        sign1_d = i_kulisch_acc[WWIDTH-1];
        zero1_d = (i_kulisch_acc == '0);
        mag1_d  = abs_word;
      end
    end
  end

  always_comb begin
    v2_d    = v2_q;
    sign2_d = sign2_q;
    zero2_d = zero2_q;
    p2_d    = p2_q;
    norm2_d = norm2_q;
    if (r2) begin
      v2_d = v1_q;
      if (v1_q) begin
        sign2_d = sign1_q;
        zero2_d = zero1_q;
        p2_d    = lead_p;
        norm2_d = mag1_q << (PW'(WWIDTH - 1) - lead_p);
      end
    end
  end

  always_comb begin
    v3_d    = v3_q;
    data3_d = data3_q;
    ovf3_d  = ovf3_q;
    inx3_d  = inx3_q;
    if (r3) begin
      v3_d = v2_q;
      if (v2_q) begin
        if (zero2_q) begin
          data3_d = '0;
          ovf3_d  = 1'b0;
          inx3_d  = 1'b0;
        end else if (p2_q < PW'(MWIDTH)) begin
          data3_d = {sign2_q, {EWIDTH{1'b0}}, sub_mant};
          ovf3_d  = 1'b0;
          inx3_d  = 1'b0;
        end else if (exp_r >= XW'(EMAX_I)) begin
          data3_d = {sign2_q, {EWIDTH{1'b1}}, {MWIDTH{1'b0}}};
          ovf3_d  = 1'b1;
          inx3_d  = 1'b1;
        end else begin
          // A mantissa carry leaves mant_r[MWIDTH-1:0] at zero and bumps exp_r.
          data3_d = {sign2_q, exp_r[EWIDTH-1:0], mant_r[MWIDTH-1:0]};
          ovf3_d  = 1'b0;
          inx3_d  = guard || sticky;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      sign1_q <= 1'b0;
      zero1_q <= 1'b0;
      mag1_q  <= '0;
      v2_q    <= 1'b0;
      sign2_q <= 1'b0;
      zero2_q <= 1'b0;
      p2_q    <= '0;
      norm2_q <= '0;
      v3_q    <= 1'b0;
      data3_q <= '0;
      ovf3_q  <= 1'b0;
      inx3_q  <= 1'b0;
    end else begin
      v1_q    <= v1_d;
      sign1_q <= sign1_d;
      zero1_q <= zero1_d;
      mag1_q  <= mag1_d;
      v2_q    <= v2_d;
      sign2_q <= sign2_d;
      zero2_q <= zero2_d;
      p2_q    <= p2_d;
      norm2_q <= norm2_d;
      v3_q    <= v3_d;
      data3_q <= data3_d;
      ovf3_q  <= ovf3_d;
      inx3_q  <= inx3_d;
    end
  end

endmodule

// File: tb/tb_kulisch_to_fp16.sv
// Scoreboard bench for kulisch_to_fp16: directed words with hand-computed binary16 results,
// backpressure, random bubbles and mid-stream reset.
module tb_kulisch_to_fp16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [78:0] i_kulisch_acc;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_fp_data;
  logic        o_overflow;
  logic        o_inexact;

  kulisch_to_fp16 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_kulisch_acc(i_kulisch_acc),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_fp_data    (o_fp_data),
    .o_overflow   (o_overflow),
    .o_inexact    (o_inexact)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [78:0] vw[$];
  logic [17:0] ve[$];   // {fp16, overflow, inexact}
  logic [17:0] sb[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  task automatic add(input logic [78:0] w, input logic [15:0] d, input logic ov, input logic ix);
    vw.push_back(w);
    ve.push_back({d, ov, ix});
  endtask

  function automatic logic [78:0] neg(input logic [78:0] w);
    return 79'(0) - w;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the word is accepted.
  task automatic send(input int idx);
    int t = 0;
    i_valid       = 1'b1;
    i_kulisch_acc = vw[idx];
    @(negedge clk);
    while (!o_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!o_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got o_ready=%0b want 1 (vector %0d)", o_ready, idx);
    end else begin
      sb.push_back(ve[idx]);
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int t = 0;
    @(posedge clk);
    #1;
    while ((sb.size() != 0 || o_valid) && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk(nm, 32'(sb.size()), 32'd0);
  endtask

  // Monitor: pops and compares on every output handshake, and checks holds while stalled.
  initial begin : monitor
    logic        hold;
    logic [17:0] held, got;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        got = {o_fp_data, o_overflow, o_inexact};
        if (hold && o_valid) chk("stall_hold", 32'(got), 32'(held));
        if (o_valid && i_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output got %h want none", got);
          end else begin
            chk("result", 32'(got), 32'(sb.pop_front()));
          end
          hold = 1'b0;
        end else if (o_valid) begin
          hold = 1'b1;
          held = got;
        end else begin
          hold = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic done;
    add(79'(1) << 24,                 16'h3C00, 1'b0, 1'b0);
    add(neg(79'(1) << 24),            16'hBC00, 1'b0, 1'b0);
    add(79'(0),                       16'h0000, 1'b0, 1'b0);
    add(79'(1),                       16'h0001, 1'b0, 1'b0);
    add(79'h3FF,                      16'h03FF, 1'b0, 1'b0);
    add(79'h400,                      16'h0400, 1'b0, 1'b0);
    add((79'(1) << 24) + (79'(1) << 13), 16'h3C00, 1'b0, 1'b1);
    add((79'(1) << 24) + (79'(3) << 13), 16'h3C02, 1'b0, 1'b1);
    add((79'(1) << 24) + 79'(1),      16'h3C00, 1'b0, 1'b1);
    add(79'(65504) << 24,             16'h7BFF, 1'b0, 1'b0);
    add(79'(65520) << 24,             16'h7C00, 1'b1, 1'b1);
    add(79'(1) << 78,                 16'hFC00, 1'b1, 1'b1);
    add((79'(1) << 24) + (79'(3) << 12), 16'h3C01, 1'b0, 1'b1);
    add(neg((79'(1) << 24) + (79'(3) << 13)), 16'hBC02, 1'b0, 1'b1);
    add(neg(79'(1)),                  16'h8001, 1'b0, 1'b0);
    add(79'(1) << 63,                 16'h7C00, 1'b1, 1'b1);

    rst_n         = 1'b0;
    i_valid       = 1'b0;
    i_ready       = 1'b1;
    i_kulisch_acc = '0;
    repeat (2) @(negedge clk);
    chk("reset_o_valid", 32'(o_valid), 32'd0);
    chk("reset_o_fp_data", 32'(o_fp_data), 32'd0);
    chk("reset_flags", 32'({o_overflow, o_inexact}), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(o_ready), 32'd1);
    @(posedge clk);
    #1;

    // Directed vectors, streaming back-to-back with the consumer always ready.
    for (int i = 0; i < vw.size(); i++) send(i);
    drain("drain_directed");

    // Backpressure: three words fill the pipe, two more wait for the consumer.
    i_ready = 1'b0;
    send(0);
    send(7);
    send(11);
    @(negedge clk);
    chk("bp_o_ready_low", 32'(o_ready), 32'd0);
    chk("bp_o_valid", 32'(o_valid), 32'd1);
    @(posedge clk);
    #1;
    fork
      begin
        send(3);
        send(13);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        i_ready = 1'b1;
      end
    join
    drain("drain_backpressure");

    // Random input gaps with a randomly stalling consumer.
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
          send((k * 7) % vw.size());
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          i_ready = ($urandom_range(0, 1) == 1);
        end
      end
    join
    i_ready = 1'b1;
    drain("drain_random");

    // Reset with three words in flight: everything in the pipe is discarded.
    i_ready = 1'b0;
    send(9);
    send(10);
    send(12);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midreset_o_valid", 32'(o_valid), 32'd0);
    chk("midreset_o_fp_data", 32'(o_fp_data), 32'd0);
    chk("midreset_flags", 32'({o_overflow, o_inexact}), 32'd0);
    i_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midreset_ready", 32'(o_ready), 32'd1);
    @(posedge clk);
    #1;
    send(5);
    send(14);
    drain("drain_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kulisch_to_fp16.md
# kulisch_to_fp16

Pipelined normalizer that converts the wide two's-complement Kulisch accumulator word into an IEEE-754 binary16 value with round-to-nearest-even. It sits directly downstream of `kulisch_acc_fp16` and consumes its `o_kulisch_acc` bus. It returns accumulated results to the FP16 datapath with valid/ready flow control and overflow/inexact flags.

## Interface
- `DWIDTH`, 16: FP output width
- `EWIDTH`, 5: exponent width
- `MWIDTH`, 10: stored mantissa width
- `BIAS`, 15: exponent bias
- `WWIDTH`, 79: Kulisch word width
- `FBITS`, 24: fractional bits of the Kulisch word (LSB weight 2^-24 = FP16 min subnormal)

- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `i_valid`  in  1  input word valid
- `o_ready`  out  1  block accepts input this cycle
- `i_kulisch_acc`  in  WWIDTH  signed accumulator; value = signed(word) * 2^-FBITS
- `o_valid`  out  1  output valid
- `i_ready`  in  1  consumer accepts output
- `o_fp_data`  out  DWIDTH  binary16 result
- `o_overflow`  out  1  result saturated to ±Inf
- `o_inexact`  out  1  nonzero bits discarded by rounding

## Operation
- Three registered stages (S1, S2, S3), each with its own valid bit v1..v3.
- S1 (capture/abs): sign = word MSB; mag = |word| as unsigned WWIDTH bits (the most negative word, -2^78, is representable as unsigned 2^78); zero flag = (mag == 0).
- S2 (normalize): p = index of leading one of mag (0..WWIDTH-1). Store sign, zero, p, and mag left-shifted so that bit p sits at bit WWIDTH-1.
- S3 (round/pack), with unbiased exponent e = p - FBITS:
  - zero → ±0 is not produced; output 0x0000, flags 0.
  - p <= MWIDTH (e <= -14): exact. If p < MWIDTH, subnormal {sign, 00000, mag[9:0]}; if p == MWIDTH, normal exponent 1, mantissa mag[9:0]. Inexact = 0.
  - p > MWIDTH: mantissa = 10 bits below the leading one; guard = next bit; sticky = OR of all lower bits. Round up if guard & (sticky | mantissa LSB). Mantissa carry-out increments the exponent and clears the mantissa. Biased exponent = e + BIAS. inexact = guard | sticky.
  - Biased exponent >= 31 (before or after rounding) → {sign, 11111, 0}, o_overflow = 1, o_inexact = 1.
- NaN is never produced.

## Timing
- Latency: 3 cycles from input handshake (i_valid & o_ready) to o_valid, with no stalls. Throughput is 1 word/cycle.
- Per-stage ready, combinational chain:
  - r3 = !v3 | i_ready
  - r2 = !v2 | r3
  - r1 = !v1 | r2
  - o_ready = r1
- Bubbles collapse. A stage loads when its ready is high. Its valid takes the upstream valid (S1 takes i_valid & o_ready).
- Output hold: while o_valid & !i_ready, o_fp_data, o_overflow and o_inexact are stable, and no stage holding valid data is overwritten.
- o_ready depends combinationally on i_ready. No combinational path runs from i_kulisch_acc or i_valid to any output.
- Reset (async assert, any time including mid-stream): v1..v3 = 0, o_valid = 0, o_fp_data = 0, o_overflow = 0, o_inexact = 0. In-flight data is discarded. o_ready = 1 from the first cycle after reset release.
- Input accepted in the same cycle the full pipe drains a word (i_ready = 1, all valid): all stages shift together, no data lost.

## Test plan
- Basic values, i_ready held 1:
  - word 1<<24 → 0x3C00 after 3 cycles.
  - word -(1<<24) → 0xBC00.
  - word 0 → 0x0000.
  - word 1 → 0x0001.
  - word 0x3FF → 0x03FF.
  - word 0x400 → 0x0400.
  - All with flags 0.
- Rounding:
  - (1<<24)+(1<<13) (tie, even) → 0x3C00, inexact = 1.
  - (1<<24)+(3<<13) → 0x3C02, inexact = 1.
  - (1<<24)+1 → 0x3C00, inexact = 1.
- Range limits:
  - 65504<<24 → 0x7BFF, flags 0.
  - 65520<<24 → 0x7C00, overflow = 1.
  - Most negative word (bit 78 only) → 0xFC00, overflow = 1.
- Backpressure:
  - Stream 5 words back-to-back with i_ready = 0.
  - o_ready drops after 3 accepted.
  - Raise i_ready: all 5 emerge in order, no loss or duplication.
  - o_fp_data is stable throughout each stall.
- Bubble collapse: input gaps with i_ready toggling randomly; the output sequence matches a reference model in order.
- Reset mid-stream: assert rst_n low with 3 words in flight → o_valid = 0 immediately; after release, only new inputs appear at the output.
